mul_div_unit: RTL and testbench

//   Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS execute stage.

---
 rtl/mul_div_unit.sv | 175 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MIPS multiply/divide unit with architectural HI/LO.
// Iterative shift-add multiply and restoring divide, one bit per cycle, over
// magnitudes with a final sign fix. MTHI/MTLO, divide-by-zero and unused ops
// complete in one cycle.
// Optional macro MDU_FAST_MUL_EN: MULT/MULTU use a single-cycle 64-bit product.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic                  cancel,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2*W-1:0]       r_acc;    // mul: {partial, multiplier}; div: {rem, dividend/quotient}
  logic [W-1:0]         r_opnd;   // multiplicand or divisor magnitude
  logic [W-1:0]         r_hi, r_lo;
  logic                 r_neg_q, r_neg_r, r_done, r_dbz;

  logic          w_accept, w_signed, w_neg_a, w_neg_b;
  logic [W-1:0]  w_abs_a, w_abs_b;
  logic [W-1:0]  w_addend;
  logic [W:0]    w_sum;
  logic [2*W-1:0] w_mul_nxt, w_prod_fix;
  logic [W:0]    w_sh;
  logic          w_ge;
  logic [W-1:0]  w_sub, w_rem, w_quo, w_rem_fix, w_quo_fix;
  logic [2*W-1:0] w_div_nxt;

  assign req_ready = (r_state == S_IDLE) && !cancel && !reset;
  assign w_accept  = req_valid && req_ready;
  assign w_signed  = ~req_op[0];
  assign w_neg_a   = w_signed & req_a[W-1];
  assign w_neg_b   = w_signed & req_b[W-1];
  assign w_abs_a   = w_neg_a ? -req_a : req_a;
  assign w_abs_b   = w_neg_b ? -req_b : req_b;

  // Shift-add step: add multiplicand when the current multiplier bit is set, shift right.
  assign w_addend   = r_acc[0] ? r_opnd : '0;
  assign w_sum      = {1'b0, r_acc[2*W-1:W]} + {1'b0, w_addend};
  assign w_mul_nxt  = {w_sum, r_acc[W-1:1]};
  assign w_prod_fix = r_neg_q ? -w_mul_nxt : w_mul_nxt;

  // Restoring step: shift next dividend bit into the remainder, subtract if it fits.
  assign w_sh      = r_acc[2*W-1:W-1];
  assign w_ge      = w_sh >= {1'b0, r_opnd};
  assign w_sub     = w_sh[W-1:0] - r_opnd;
  assign w_rem     = w_ge ? w_sub : w_sh[W-1:0];
  assign w_quo     = {r_acc[W-2:0], w_ge};
  assign w_div_nxt = {w_rem, w_quo};
  assign w_quo_fix = r_neg_q ? -w_quo : w_quo;
  assign w_rem_fix = r_neg_r ? -w_rem : w_rem;

`ifdef MDU_FAST_MUL_EN
  logic [2*W-1:0] w_fa, w_fb, w_fprod;
  assign w_fa    = {{W{w_neg_a}}, req_a};
  assign w_fb    = {{W{w_neg_b}}, req_b};
  assign w_fprod = w_fa * w_fb;
`endif

  assign busy        = (r_state == S_MUL) || (r_state == S_DIV);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

  // Control FSM, iteration datapath and HI/LO commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_cnt   <= '0;
          r_neg_q <= w_neg_a ^ w_neg_b;
          r_neg_r <= w_neg_a;
          case (req_op)
            3'b000, 3'b001: begin
`ifdef MDU_FAST_MUL_EN
              {r_hi, r_lo} <= w_fprod;
              r_done       <= 1'b1;
              r_state      <= S_DONE;
`else
              r_acc   <= {{W{1'b0}}, w_abs_b};
              r_opnd  <= w_abs_a;
              r_state <= S_MUL;
`endif
            end
            3'b010, 3'b011: begin
              if (req_b == '0) begin
                r_dbz   <= 1'b1;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_acc   <= {{W{1'b0}}, w_abs_a};
                r_opnd  <= w_abs_b;
                r_state <= S_DIV;
              end
            end
            3'b100: begin
              r_hi    <= req_a;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
            3'b101: begin
              r_lo    <= req_a;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
            default: begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          endcase
        end
        S_MUL: begin
          if (cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_mul_nxt;
            r_cnt <= r_cnt + CNT_WIDTH'(1);
            if (r_cnt == LAST) begin
              {r_hi, r_lo} <= w_prod_fix;
              r_done       <= 1'b1;
              r_state      <= S_DONE;
            end
          end
        end
        S_DIV: begin
          if (cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_div_nxt;
            r_cnt <= r_cnt + CNT_WIDTH'(1);
            if (r_cnt == LAST) begin
              r_hi    <= w_rem_fix;
              r_lo    <= w_quo_fix;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table through a scoreboard queue,
// random MULT/DIV against a native-arithmetic model, and hand-written
// cancel / back-to-back / reset-mid-operation sequences.
module tb_mul_div_unit;
`ifdef MDU_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, cancel = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        req_ready, busy, done, div_by_zero;
  logic [31:0] hi, lo;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .cancel(cancel),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vec[16];
  vec_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_hi, m_lo;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb64;
    logic signed [31:0] qa, qb;
    case (op)
      3'd0: begin
        sa = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        return sa * sb64;
      end
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        qa = a;
        qb = b;
        return {32'(qa % qb), 32'(qa / qb)};
      end
      default: return {a % b, a / b};
    endcase
  endfunction

  // Issue one op, push expectation, wait for done, pop and compare.
  task automatic run_op(input string nm, input vec_t v);
    int n;
    vec_t e;
    sb.push_back(v);
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check({nm, "_ready_timeout"}, 0, 1);
    req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({nm, "_busy"}, busy, (v.lat > 1));
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    if (!done) begin
      check({nm, "_done_timeout"}, 0, 1);
    end else begin
      check({nm, "_lat"}, n + 1, e.lat);
      check({nm, "_hi"}, hi, e.hi);
      check({nm, "_lo"}, lo, e.lo);
      check({nm, "_dbz"}, div_by_zero, e.dbz);
      @(posedge clk); #1;
      check({nm, "_done_pulse"}, done, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, ML};
    vec[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, ML};
    vec[2]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, ML};
    vec[3]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vec[4]  = '{3'd3, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 33};
    vec[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vec[6]  = '{3'd4, 32'h11,       32'h0,        32'h11,       32'h80000000, 1'b0, 1};
    vec[7]  = '{3'd5, 32'h22,       32'h0,        32'h11,       32'h22,       1'b0, 1};
    vec[8]  = '{3'd3, 32'd5,        32'd0,        32'h11,       32'h22,       1'b1, 1};
    vec[9]  = '{3'd4, 32'hABCD,     32'h0,        32'hABCD,     32'h22,       1'b0, 1};
    vec[10] = '{3'd6, 32'h1,        32'h2,        32'hABCD,     32'h22,       1'b0, 1};
    vec[11] = '{3'd2, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, 33};
    vec[12] = '{3'd2, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 33};
    vec[13] = '{3'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, ML};
    vec[14] = '{3'd2, 32'd5,        32'd0,        32'hFFFFFFFF, 32'h80000001, 1'b1, 1};
    vec[15] = '{3'd3, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 33};

    // Reset state
    #12;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_ready", req_ready, 0);
    @(negedge clk); reset = 1'b0;
    #1 check("post_rst_ready", req_ready, 1);

    for (int i = 0; i < 16; i++) run_op($sformatf("v%0d", i), vec[i]);
    m_hi = vec[15].hi;
    m_lo = vec[15].lo;

    // Random MULT/MULTU/DIV/DIVU against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      logic [63:0] r;
      v.op = 3'($urandom_range(0, 3));
      v.a = $urandom;
      v.b = $urandom;
      if (v.op >= 3'd2 && v.b == 0) v.b = 32'd1;
      if (v.op == 3'd2 && v.a == 32'h80000000 && v.b == 32'hFFFFFFFF) v.b = 32'd3;
      r = model(v.op, v.a, v.b);
      v.hi = r[63:32]; v.lo = r[31:0]; v.dbz = 1'b0;
      v.lat = (v.op < 3'd2) ? ML : 33;
      run_op($sformatf("rnd%0d", i), v);
      m_hi = v.hi; m_lo = v.lo;
    end

    // Cancel a DIV at iteration 10: no done, hi/lo untouched, ready again
    begin
      int seen;
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd2; req_a = 32'd1000; req_b = 32'd3;
      @(posedge clk); #1 req_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk) cancel = 1'b1;
      check("cxl_busy_before", busy, 1);
      @(posedge clk); #1 cancel = 1'b0;
      #0 check("cxl_busy_after", busy, 0);
      check("cxl_ready", req_ready, 1);
      seen = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (done) seen++;
      end
      check("cxl_no_done", seen, 0);
      check("cxl_hi", hi, m_hi);
      check("cxl_lo", lo, m_lo);
    end

    // req_valid held during busy must not be accepted
    begin
      int bad, n;
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd3; req_a = 32'd100; req_b = 32'd7;
      @(posedge clk); #1;
      req_op = 3'd4; req_a = 32'hDEAD;
      bad = 0;
      repeat (5) begin
        @(posedge clk); #1;
        if (req_ready) bad++;
      end
      req_valid = 1'b0;
      check("b2b_not_ready", bad, 0);
      n = 0;
      while (!done && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("b2b_done", done, 1);
      check("b2b_hi", hi, 32'd2);
      check("b2b_lo", lo, 32'd14);
      m_hi = 32'd2; m_lo = 32'd14;
    end

    // cancel in IDLE blocks accept
    @(negedge clk);
    cancel = 1'b1; req_valid = 1'b1; req_op = 3'd4; req_a = 32'h777;
    #1 check("idle_cxl_ready", req_ready, 0);
    @(posedge clk); #1;
    check("idle_cxl_done", done, 0);
    req_valid = 1'b0; cancel = 1'b0;
    check("idle_cxl_hi", hi, m_hi);

    // cancel during DONE is ignored
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; req_a = 32'h99;
    @(posedge clk); #1;
    req_valid = 1'b0; cancel = 1'b1;
    check("done_cxl_done", done, 1);
    check("done_cxl_lo", lo, 32'h99);
    @(posedge clk); #1 cancel = 1'b0;
    check("done_cxl_pulse", done, 0);

    // Reset at iteration 20 of an iterative op
    @(negedge clk);
`ifdef MDU_FAST_MUL_EN
    req_op = 3'd3;
`else
    req_op = 3'd1;
`endif
    req_valid = 1'b1; req_a = 32'hFFFFFFFF; req_b = 32'hFFFFFFFF;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1;
    check("mid_rst_hi", hi, 0);
    check("mid_rst_lo", lo, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", req_ready, 0);
    @(negedge clk) reset = 1'b0;
    run_op("mtlo_after_rst", '{3'd5, 32'h5, 32'h0, 32'h0, 32'h5, 1'b0, 1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
